// File: rtl/tomasula_types.sv
// Shared instruction-class encoding for the Tomasulo front end.
package tomasula_types;

  typedef enum logic [2:0] {
    OP_ALU    = 3'd0,
    OP_LD     = 3'd1,
    OP_ST     = 3'd2,
    OP_BRANCH = 3'd3,
    OP_MUL    = 3'd4,
    OP_DIV    = 3'd5,
    OP_JUMP   = 3'd6,
    OP_NOP    = 3'd7
  } op_t;

endpackage : tomasula_types

// File: rtl/instr_queue_if.sv
// Decode-to-queue and queue-to-ROB/RS signal bundle for instr_queue.
// master = decode/ROB side, slave = the queue itself.
interface instr_queue_if;
  import tomasula_types::*;

  // Enqueue side (from decode)
  logic        enq_valid;
  logic        enq_ready;
  op_t         enq_op;
  logic [4:0]  enq_rd;
  logic [4:0]  enq_rs1;
  logic [4:0]  enq_rs2;
  logic [31:0] enq_imm;
  logic [31:0] enq_pc;
  logic        enq_pred_taken;

  // Back-pressure and control from ROB / reservation stations
  logic        rob_full;
  logic        rs_full;
  logic        flush_in_prog;
  logic [2:0]  curr_ptr;

  // Issue side (to ROB and reservation station)
  logic        rob_load;
  op_t         instr_type;
  logic [4:0]  rd;
  logic [4:0]  st_src;
  logic [4:0]  iss_rs1;
  logic [4:0]  iss_rs2;
  logic [31:0] iss_imm;
  logic [31:0] iss_pc;
  logic [2:0]  iss_tag;
  logic [3:0]  count;

  modport master (
    output enq_valid, enq_op, enq_rd, enq_rs1, enq_rs2, enq_imm, enq_pc,
           enq_pred_taken, rob_full, rs_full, flush_in_prog, curr_ptr,
    input  enq_ready, rob_load, instr_type, rd, st_src, iss_rs1, iss_rs2,
           iss_imm, iss_pc, iss_tag, count
  );

  modport slave (
    input  enq_valid, enq_op, enq_rd, enq_rs1, enq_rs2, enq_imm, enq_pc,
           enq_pred_taken, rob_full, rs_full, flush_in_prog, curr_ptr,
    output enq_ready, rob_load, instr_type, rd, st_src, iss_rs1, iss_rs2,
           iss_imm, iss_pc, iss_tag, count
  );

endinterface : instr_queue_if

// File: rtl/instr_queue.sv
// 8-entry in-order instruction queue between decode and the ROB /
// reservation stations. Issues from the head whenever the back end can
// accept, and empties itself while a mispredict flush is in progress.
module instr_queue
  import tomasula_types::*;
(
  input  logic          clk,
  input  logic          rst,   // asynchronous, active-low
  instr_queue_if.slave  iq
);

  localparam int unsigned DEPTH = 8;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // One queued instruction. rd/st_src are stored already in their ROB
  // form so the issue path is a plain read of the head entry.
  typedef struct packed {
    op_t         op;
    logic [4:0]  rd;
    logic [4:0]  st_src;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
  } entry_t;

  state_t      state_q, state_d;
  logic [2:0]  head_q, head_d;
  logic [2:0]  tail_q, tail_d;
  logic [3:0]  count_q, count_d;
  entry_t      mem_q [DEPTH];

  logic        running;
  logic        do_enq;
  logic        do_iss;
  entry_t      new_entry;
  entry_t      head_entry;

  // Handshake qualifiers: nothing moves outside RUN or during a flush.
  always_comb begin
    running = (state_q == ST_RUN) && !iq.flush_in_prog;
    do_enq  = running && iq.enq_valid && (count_q != 4'd8);
    do_iss  = running && (count_q != 4'd0) && !iq.rob_full && !iq.rs_full;
  end

  // Shape the incoming instruction into its ROB-facing form.
  always_comb begin
    new_entry     = '0;
    new_entry.op  = iq.enq_op;
    new_entry.rs1 = iq.enq_rs1;
    new_entry.rs2 = iq.enq_rs2;
    new_entry.imm = iq.enq_imm;
    new_entry.pc  = iq.enq_pc;
    unique case (iq.enq_op)
      OP_ST: begin
        new_entry.rd     = 5'd0;
        new_entry.st_src = iq.enq_rs2;
      end
      OP_BRANCH: begin
        // Branches carry their prediction in the rd slot for the ROB.
        new_entry.rd     = {3'b000, iq.enq_pred_taken, 1'b0};
        new_entry.st_src = 5'd0;
      end
      default: begin
        new_entry.rd     = iq.enq_rd;
        new_entry.st_src = 5'd0;
      end
    endcase
  end

  // Next-state logic for the FSM, pointers and occupancy.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    unique case (state_q)
      ST_RUN: begin
        if (iq.flush_in_prog) begin
          // Squash everything queued; the flushed path is dead.
          state_d = ST_FLUSH;
          tail_d  = head_q;
          count_d = 4'd0;
        end else begin
          if (do_enq) tail_d = tail_q + 3'd1;   // 3-bit pointer wraps 7->0
          if (do_iss) head_d = head_q + 3'd1;
          unique case ({do_enq, do_iss})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
          endcase
        end
      end
      ST_FLUSH: begin
        if (!iq.flush_in_prog) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State, pointer and count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      head_q  <= 3'd0;
      tail_q  <= 3'd0;
      count_q <= 4'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage, written at the tail on enqueue.
  // NOTE: the storage array is deliberately not reset; count/pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_enq) mem_q[tail_q] <= new_entry;
  end

  // Issue outputs come straight from the head entry.
  always_comb begin
    head_entry    = mem_q[head_q];
    iq.enq_ready  = running && (count_q != 4'd8);
    iq.rob_load   = do_iss;
    iq.instr_type = head_entry.op;
    iq.rd         = head_entry.rd;
    iq.st_src     = head_entry.st_src;
    iq.iss_rs1    = head_entry.rs1;
    iq.iss_rs2    = head_entry.rs2;
    iq.iss_imm    = head_entry.imm;
    iq.iss_pc     = head_entry.pc;
    iq.iss_tag    = iq.curr_ptr;
    iq.count      = count_q;
  end

endmodule : instr_queue

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue.
module tb_instr_queue;
  import tomasula_types::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  instr_queue_if iq ();

  instr_queue dut (
    .clk (clk),
    .rst (rst),
    .iq  (iq.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_enq(input op_t op, input logic [4:0] rdv, input logic [4:0] rs2v,
                           input logic pred);
    iq.enq_valid      = 1'b1;
    iq.enq_op         = op;
    iq.enq_rd         = rdv;
    iq.enq_rs1        = rdv + 5'd1;
    iq.enq_rs2        = rs2v;
    iq.enq_imm        = {27'd0, rdv} + 32'h100;
    iq.enq_pc         = {27'd0, rdv} << 2;
    iq.enq_pred_taken = pred;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    iq.enq_valid      = 1'b0;
    iq.enq_op         = OP_ALU;
    iq.enq_rd         = 5'd0;
    iq.enq_rs1        = 5'd0;
    iq.enq_rs2        = 5'd0;
    iq.enq_imm        = 32'd0;
    iq.enq_pc         = 32'd0;
    iq.enq_pred_taken = 1'b0;
    iq.rob_full       = 1'b0;
    iq.rs_full        = 1'b0;
    iq.flush_in_prog  = 1'b0;
    iq.curr_ptr       = 3'd2;

    // Reset state
    step(); step();
    rst = 1'b1;
    #1;
    check("rst_count", 32'(iq.count), 32'd0);
    check("rst_rob_load", 32'(iq.rob_load), 32'd0);
    check("rst_enq_ready", 32'(iq.enq_ready), 32'd1);

    // ALU then ST, issued in order
    drive_enq(OP_ALU, 5'd5, 5'd2, 1'b0);
    #1;
    check("empty_no_bypass", 32'(iq.rob_load), 32'd0);
    step();
    drive_enq(OP_ST, 5'd7, 5'd9, 1'b0);
    #1;
    check("alu_rob_load", 32'(iq.rob_load), 32'd1);
    check("alu_type", 32'(iq.instr_type), 32'(OP_ALU));
    check("alu_rd", 32'(iq.rd), 32'd5);
    check("alu_tag", 32'(iq.iss_tag), 32'd2);
    check("alu_imm", iq.iss_imm, 32'h105);
    step();
    iq.enq_valid = 1'b0;
    #1;
    check("enq_iss_count", 32'(iq.count), 32'd1);
    check("st_rob_load", 32'(iq.rob_load), 32'd1);
    check("st_type", 32'(iq.instr_type), 32'(OP_ST));
    check("st_rd", 32'(iq.rd), 32'd0);
    check("st_src", 32'(iq.st_src), 32'd9);
    step();
    check("drain_count", 32'(iq.count), 32'd0);

    // Fill to 8 while the ROB is full (head is at 2, so this wraps)
    iq.rob_full = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_enq(OP_ALU, 5'(10 + i), 5'd0, 1'b0);
      step();
    end
    check("full_count", 32'(iq.count), 32'd8);
    check("full_enq_ready", 32'(iq.enq_ready), 32'd0);
    check("full_rob_load", 32'(iq.rob_load), 32'd0);
    drive_enq(OP_ALU, 5'd31, 5'd0, 1'b0);
    step();
    check("ninth_dropped", 32'(iq.count), 32'd8);

    // Full queue: issue happens, enqueue still refused
    iq.rob_full = 1'b0;
    #1;
    check("full_iss_rob_load", 32'(iq.rob_load), 32'd1);
    check("full_iss_enq_ready", 32'(iq.enq_ready), 32'd0);
    check("full_iss_rd", 32'(iq.rd), 32'd10);
    step();
    iq.enq_valid = 1'b0;
    check("full_iss_count", 32'(iq.count), 32'd7);

    // Stall on rs_full: head holds
    iq.rs_full = 1'b1;
    #1;
    check("stall_rob_load", 32'(iq.rob_load), 32'd0);
    step();
    iq.rs_full = 1'b0;
    #1;
    check("stall_count", 32'(iq.count), 32'd7);

    // Drain the rest in FIFO order
    for (int i = 1; i < 8; i++) begin
      check($sformatf("drain_rd_%0d", i), 32'(iq.rd), 32'(10 + i));
      check($sformatf("drain_load_%0d", i), 32'(iq.rob_load), 32'd1);
      step();
    end
    check("drained_count", 32'(iq.count), 32'd0);

    // BRANCH taken, then LD
    drive_enq(OP_BRANCH, 5'd7, 5'd4, 1'b1);
    step();
    drive_enq(OP_LD, 5'd3, 5'd4, 1'b1);
    #1;
    check("br_type", 32'(iq.instr_type), 32'(OP_BRANCH));
    check("br_rd", 32'(iq.rd), 32'd2);
    check("br_st_src", 32'(iq.st_src), 32'd0);
    step();
    iq.enq_valid = 1'b0;
    #1;
    check("ld_rd", 32'(iq.rd), 32'd3);
    check("ld_st_src", 32'(iq.st_src), 32'd0);
    step();
    check("br_ld_count", 32'(iq.count), 32'd0);

    // Flush with 4 entries queued
    iq.rob_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_enq(OP_MUL, 5'(20 + i), 5'd0, 1'b0);
      step();
    end
    iq.enq_valid = 1'b0;
    check("pre_flush_count", 32'(iq.count), 32'd4);
    iq.rob_full      = 1'b0;
    iq.flush_in_prog = 1'b1;
    iq.enq_valid     = 1'b1;
    #1;
    check("flush_enq_ready", 32'(iq.enq_ready), 32'd0);
    check("flush_rob_load", 32'(iq.rob_load), 32'd0);
    step();
    check("flush_count", 32'(iq.count), 32'd0);
    step();
    check("flush2_enq_ready", 32'(iq.enq_ready), 32'd0);
    step();
    check("flush3_count", 32'(iq.count), 32'd0);
    iq.flush_in_prog = 1'b0;
    #1;
    check("flush_state_ready", 32'(iq.enq_ready), 32'd0);
    step();
    iq.enq_valid = 1'b0;
    check("flush_exit_ready", 32'(iq.enq_ready), 32'd1);
    check("flush_exit_count", 32'(iq.count), 32'd0);

    // Asynchronous reset with 3 entries queued
    iq.rob_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_enq(OP_ALU, 5'(1 + i), 5'd0, 1'b0);
      step();
    end
    iq.enq_valid = 1'b0;
    iq.rob_full  = 1'b0;
    #1;
    check("pre_rst_rob_load", 32'(iq.rob_load), 32'd1);
    check("pre_rst_count", 32'(iq.count), 32'd3);
    rst = 1'b0;
    #1;
    check("async_rst_count", 32'(iq.count), 32'd0);
    check("async_rst_rob_load", 32'(iq.rob_load), 32'd0);
    step();
    rst = 1'b1;
    #1;
    check("post_rst_ready", 32'(iq.enq_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_instr_queue

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 clk  in  1  single clock; all state updates on posedge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 enq_valid  in  1  decode presents an instruction.
REQ-004 enq_ready  out  1  queue accepts the instruction this cycle.
REQ-005 enq_op  in  tomasula_types::op_t  instruction class (ALU, LD, ST, BRANCH, ...).
REQ-006 enq_rd / enq_rs1 / enq_rs2  in  5 each  destination and source registers.
REQ-007 enq_imm / enq_pc  in  32 each  immediate and instruction PC.
REQ-008 enq_pred_taken  in  1  branch prediction; ignored for non-BRANCH.
REQ-009 rob_full  in  1  ROB cannot allocate.
REQ-010 rs_full  in  1  target reservation station cannot accept.
REQ-011 flush_in_prog  in  1  ROB flush after branch mispredict.
REQ-012 curr_ptr  in  3  ROB allocation pointer; becomes the issued tag.
REQ-013 rob_load  out  1  issue strobe to the ROB and reservation station.
REQ-014 instr_type  out  op_t  head op.
REQ-015 rd / st_src  out  5 each  ROB rd field and store source register.
REQ-016 iss_rs1 / iss_rs2  out  5 each  head source registers.
REQ-017 iss_imm / iss_pc  out  32 each  head immediate and PC.
REQ-018 iss_tag  out  3  equals curr_ptr while rob_load=1.
REQ-019 count  out  4  occupancy, 0..8.

Function
REQ-020 The queue SHALL be an 8-entry circular FIFO with 3-bit head/tail pointers that wrap 7->0, plus a 4-bit count.
REQ-021 A two-state FSM SHALL run: RUN and FLUSH.
REQ-022 enq_ready SHALL equal (state==RUN) & ~flush_in_prog & (count!=8).
REQ-023 An enqueue SHALL occur at posedge when enq_valid & enq_ready, writing at tail; tail increments.
REQ-024 issue SHALL equal (state==RUN) & ~flush_in_prog & (count!=0) & ~rob_full & ~rs_full; rob_load SHALL equal issue (combinational).
REQ-025 On issue at posedge, head SHALL increment.
REQ-026 Outputs SHALL be driven combinationally from the head entry; an enqueue at edge N SHALL be issuable in cycle N+1 (no bypass from an empty queue).
REQ-027 For ST: rd=0 and st_src=enq_rs2. For BRANCH: rd={3'b0, pred_taken, 1'b0} and st_src=0. For all other ops: rd=enq_rd and st_src=0.
REQ-028 Simultaneous enqueue and issue SHALL leave count unchanged; otherwise count SHALL be incremented or decremented by 1.
REQ-029 A full queue (count=8) SHALL refuse enqueue even when issuing the same cycle.
REQ-030 In RUN, flush_in_prog=1 at posedge SHALL empty the queue (head=tail, count=0) and move to FLUSH; no enqueue or issue occurs that cycle.
REQ-031 In FLUSH, enq_ready=0 and rob_load=0; the FSM SHALL return to RUN at the first posedge with flush_in_prog=0.
REQ-032 rob_full or rs_full SHALL stall the head without data loss; outputs SHALL hold stable while stalled.
REQ-033 When rob_load=0, outputs other than rob_load and count may hold any value; the bench SHALL check them only with rob_load=1.

Reset
REQ-034 rst low SHALL asynchronously clear head, tail and count to 0 and set state to RUN; rob_load=0 and enq_ready=1 immediately after release.
REQ-035 Entry storage need not be reset.
REQ-036 Reset asserted mid-operation SHALL discard all entries and any flush state.

Verification
REQ-037 Enqueue ALU rd=5, then ST rs2=9, with rob_full=0 and curr_ptr=2 -> issue order ALU (rd=5, tag=2), ST (rd=0, st_src=9); count returns to 0.
REQ-038 Enqueue 8 entries with rob_full=1 -> count=8, enq_ready=0; a 9th enq_valid is dropped; release rob_full -> 8 issues in FIFO order across pointer wrap.
REQ-039 count=8, rob_full=0, enq_valid=1 -> issue occurs, enqueue refused, count=7.
REQ-040 BRANCH with pred_taken=1 -> rd=5'b00010 on issue.
REQ-041 count=4, assert flush_in_prog for 3 cycles -> count=0 after first edge, enq_ready=0 and rob_load=0 while asserted, RUN one edge after deassert.
REQ-042 Assert rst low asynchronously between edges with count=3 -> count=0 and rob_load=0 immediately, before the next posedge.
